// File: rtl/systolic_sequencer.sv
// Sequencer feeding a MAC grid: loads stationary weights from the input FIFO,
// then gathers activation vectors and issues them with a diagonal row skew.
module systolic_sequencer #(
    parameter int unsigned width_p        = 8,
    parameter int unsigned array_width_p  = 2,
    parameter int unsigned array_height_p = 2,
    parameter int unsigned num_vectors_p  = 4,
    parameter int unsigned drain_cycles_p = array_width_p + array_height_p
) (
    input  logic                                                     clk_i,
    input  logic                                                     reset_i,
    input  logic                                                     start_i,
    output logic                                                     busy_o,
    output logic                                                     done_o,
    input  logic                                                     fifo_valid_i,
    input  logic [width_p-1:0]                                       fifo_data_i,
    output logic                                                     fifo_yumi_o,
    output logic                                                     w_load_o,
    output logic [((array_height_p > 1) ? $clog2(array_height_p) : 1)-1:0] w_row_o,
    output logic [((array_width_p > 1) ? $clog2(array_width_p) : 1)-1:0]   w_col_o,
    output logic [width_p-1:0]                                       w_data_o,
    output logic [array_height_p-1:0]                                act_valid_o,
    output logic [width_p*array_height_p-1:0]                        act_data_o
);

    localparam int unsigned num_macs_lp = array_width_p * array_height_p;
    localparam int unsigned kw_lp = (num_macs_lp > 1) ? $clog2(num_macs_lp) : 1;
    localparam int unsigned gw_lp = (array_height_p > 1) ? $clog2(array_height_p) : 1;
    localparam int unsigned vw_lp = (num_vectors_p > 1) ? $clog2(num_vectors_p) : 1;
    localparam int unsigned dw_lp = (drain_cycles_p > 1) ? $clog2(drain_cycles_p) : 1;
    localparam int unsigned rw_lp = (array_height_p > 1) ? $clog2(array_height_p) : 1;
    localparam int unsigned cw_lp = (array_width_p > 1) ? $clog2(array_width_p) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        GATHER = 3'd2,
        ISSUE  = 3'd3,
        DRAIN  = 3'd4
    } state_e;

    state_e                                  state_q, state_d;
    logic [kw_lp-1:0]                        k_cnt_q, k_cnt_d;
    logic [gw_lp-1:0]                        g_cnt_q, g_cnt_d;
    logic [vw_lp-1:0]                        vec_cnt_q, vec_cnt_d;
    logic [dw_lp-1:0]                        drain_cnt_q, drain_cnt_d;
    logic [array_height_p-1:0][width_p-1:0]  vec_buf_q, vec_buf_d;
    logic                                    done_q, done_d;
    logic                                    pop_c;
    logic                                    issue_c;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            k_cnt_q     <= '0;
            g_cnt_q     <= '0;
            vec_cnt_q   <= '0;
            drain_cnt_q <= '0;
            vec_buf_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            g_cnt_q     <= g_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            vec_buf_q   <= vec_buf_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; pops only happen while loading weights or gathering
    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        g_cnt_d     = g_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        drain_cnt_d = drain_cnt_q;
        vec_buf_d   = vec_buf_q;
        done_d      = 1'b0;
        issue_c     = 1'b0;
        pop_c       = fifo_valid_i & ((state_q == LOAD_W) | (state_q == GATHER));

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = LOAD_W;
                    k_cnt_d   = '0;
                    g_cnt_d   = '0;
                    vec_cnt_d = '0;
                end
            end
            LOAD_W: begin
                if (pop_c) begin
                    if (k_cnt_q == kw_lp'(num_macs_lp - 1)) begin
                        k_cnt_d = '0;
                        g_cnt_d = '0;
                        state_d = GATHER;
                    end else begin
                        k_cnt_d = k_cnt_q + kw_lp'(1);
                    end
                end
            end
            GATHER: begin
                if (pop_c) begin
                    vec_buf_d[g_cnt_q] = fifo_data_i;
                    if (g_cnt_q == gw_lp'(array_height_p - 1)) begin
                        g_cnt_d = '0;
                        state_d = ISSUE;
                    end else begin
                        g_cnt_d = g_cnt_q + gw_lp'(1);
                    end
                end
            end
            ISSUE: begin
                issue_c = 1'b1;
                if (vec_cnt_q == vw_lp'(num_vectors_p - 1)) begin
                    vec_cnt_d   = '0;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    vec_cnt_d = vec_cnt_q + vw_lp'(1);
                    state_d   = GATHER;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == dw_lp'(drain_cycles_p - 1)) begin
                    drain_cnt_d = '0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + dw_lp'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Weight strobe shares the pop cycle; address derived row-major from k_cnt
    always_comb begin
        fifo_yumi_o = pop_c;
        w_load_o    = pop_c & (state_q == LOAD_W);
        w_row_o     = '0;
        w_col_o     = '0;
        w_data_o    = '0;
        if (w_load_o) begin
            w_row_o  = rw_lp'(32'(k_cnt_q) / array_width_p);
            w_col_o  = cw_lp'(32'(k_cnt_q) % array_width_p);
            w_data_o = fifo_data_i;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

    // Row r delays its slot of the issued vector by r extra cycles
    for (genvar r = 0; r < array_height_p; r++) begin : g_row
        logic [r:0]              v_q, v_d;
        logic [r:0][width_p-1:0] d_q, d_d;

        always_comb begin
            v_d    = v_q << 1;
            v_d[0] = issue_c;
            d_d    = d_q << width_p;
            d_d[0] = issue_c ? vec_buf_q[r] : '0;
        end

        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                v_q <= '0;
                d_q <= '0;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end

        assign act_valid_o[r]                     = v_q[r];
        assign act_data_o[r*width_p +: width_p]   = d_q[r];
    end

endmodule
